// File: rtl/mouse_pkg.sv
// Shared types and constants for the mouse position tracker.
package mouse_pkg;

  typedef enum logic [1:0] {IDLE, SUM, LIMIT, WRAP} state_t;

  localparam int BIT_L  = 0;
  localparam int BIT_R  = 1;
  localparam int BIT_M  = 2;
  localparam int BIT_XS = 4;
  localparam int BIT_YS = 5;
  localparam int BIT_XV = 6;
  localparam int BIT_YV = 7;

  localparam int DELTA_W = 9;

  typedef struct packed {
    logic [7:0] status;
    logic [7:0] dx;
    logic [7:0] dy;
  } packet_t;

endpackage

// File: rtl/mouse_axis_unit.sv
// One axis: PS/2 delta decode and scaling, position sum, clamp and single wrap step.
module mouse_axis_unit
  import mouse_pkg::*;
#(
  parameter int POS_W      = 10,
  parameter int MAX        = 159,
  parameter bit INVERT     = 1'b0,
  parameter int SENS_SHIFT = 0
) (
  input  logic [POS_W-1:0]        pos,
  input  logic                    sign,
  input  logic                    ovf,
  input  logic [7:0]              mag,
  input  logic signed [POS_W+1:0] acc,
  output logic signed [POS_W+1:0] sum,
  output logic signed [POS_W+1:0] step,
  output logic signed [POS_W+1:0] clamp,
  output logic                    acc_ok,
  output logic                    step_ok
);

  localparam int AW = POS_W + 2;
  localparam logic signed [AW-1:0] MAX_S   = AW'(MAX);
  localparam logic signed [AW-1:0] RANGE_S = AW'(MAX + 1);

  logic signed [DELTA_W-1:0] raw;
  logic signed [DELTA_W:0]   dirn;
  logic signed [DELTA_W:0]   scaled;

  always_comb begin
    // Overflow saturates to the extreme 9-bit value in the indicated direction.
    if (ovf) raw = sign ? {1'b1, 8'h00} : {1'b0, 8'hFF};
    else     raw = {sign, mag};
    dirn   = INVERT ? -$signed({raw[DELTA_W-1], raw}) : $signed({raw[DELTA_W-1], raw});
    scaled = dirn >>> SENS_SHIFT;
    sum    = $signed({2'b00, pos}) + AW'(scaled);
  end

  always_comb begin
    if (acc[AW-1])        step = acc + RANGE_S;
    else if (acc > MAX_S) step = acc - RANGE_S;
    else                  step = acc;

    if (acc[AW-1])        clamp = '0;
    else if (acc > MAX_S) clamp = MAX_S;
    else                  clamp = acc;

    acc_ok  = !acc[AW-1] && (acc <= MAX_S);
    step_ok = !step[AW-1] && (step <= MAX_S);
  end

endmodule

// File: rtl/mouse_pos_tracker.sv
// Turns PS/2 mouse packets into an absolute cursor position and button state,
// with bus override of the position and a one-deep pending packet buffer.
module mouse_pos_tracker
  import mouse_pkg::*;
#(
  parameter int POS_W      = 10,
  parameter int X_MAX      = 159,
  parameter int Y_MAX      = 119,
  parameter bit Y_INVERT   = 1'b1,
  parameter int SENS_SHIFT = 0
) (
  input  logic             CLK,
  input  logic             RESET,
  input  logic [7:0]       MOUSE_STATUS,
  input  logic [7:0]       MOUSE_DX,
  input  logic [7:0]       MOUSE_DY,
  input  logic             INTERRUPT,
  input  logic             WRAP_MODE,
  input  logic             SET_EN,
  input  logic [POS_W-1:0] SET_X,
  input  logic [POS_W-1:0] SET_Y,
  output logic [POS_W-1:0] POS_X,
  output logic [POS_W-1:0] POS_Y,
  output logic [2:0]       BUTTONS,
  output logic [2:0]       CLICK_PRESS,
  output logic             UPDATE_STB,
  output logic             BUSY,
  output logic             OVERRUN
);

  localparam int AW = POS_W + 2;

  state_t  state;
  logic    int_d, int_edge, pending, do_commit;
  packet_t pkt, pend_pkt, new_pkt;
  logic signed [AW-1:0] acc_x, acc_y, sum_x, sum_y, step_x, step_y, clamp_x, clamp_y, cx, cy;
  logic ok_x, ok_y, step_ok_x, step_ok_y;
  logic [POS_W-1:0] set_x_lim, set_y_lim;
  logic [2:0] pkt_buttons;

  assign int_edge    = INTERRUPT & ~int_d;
  assign new_pkt     = '{status: MOUSE_STATUS, dx: MOUSE_DX, dy: MOUSE_DY};
  assign set_x_lim   = (SET_X > POS_W'(X_MAX)) ? POS_W'(X_MAX) : SET_X;
  assign set_y_lim   = (SET_Y > POS_W'(Y_MAX)) ? POS_W'(Y_MAX) : SET_Y;
  assign pkt_buttons = {pkt.status[BIT_M], pkt.status[BIT_R], pkt.status[BIT_L]};

  mouse_axis_unit #(.POS_W(POS_W), .MAX(X_MAX), .INVERT(1'b0), .SENS_SHIFT(SENS_SHIFT)) u_axis_x (
    .pos(POS_X), .sign(pkt.status[BIT_XS]), .ovf(pkt.status[BIT_XV]), .mag(pkt.dx),
    .acc(acc_x), .sum(sum_x), .step(step_x), .clamp(clamp_x), .acc_ok(ok_x), .step_ok(step_ok_x)
  );

  mouse_axis_unit #(.POS_W(POS_W), .MAX(Y_MAX), .INVERT(Y_INVERT), .SENS_SHIFT(SENS_SHIFT)) u_axis_y (
    .pos(POS_Y), .sign(pkt.status[BIT_YS]), .ovf(pkt.status[BIT_YV]), .mag(pkt.dy),
    .acc(acc_y), .sum(sum_y), .step(step_y), .clamp(clamp_y), .acc_ok(ok_y), .step_ok(step_ok_y)
  );

  always_comb begin
    do_commit = 1'b0;
    cx = acc_x;
    cy = acc_y;
    case (state)
      LIMIT: begin
        if (!WRAP_MODE) begin
          do_commit = 1'b1;
          cx = clamp_x;
          cy = clamp_y;
        end else begin
          do_commit = ok_x && ok_y;
        end
      end
      WRAP: begin
        cx = step_x;
        cy = step_y;
        do_commit = step_ok_x && step_ok_y;
      end
      default: ;
    endcase
  end

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      state       <= IDLE;
      int_d       <= 1'b0;
      pending     <= 1'b0;
      pkt         <= '0;
      pend_pkt    <= '0;
      acc_x       <= '0;
      acc_y       <= '0;
      POS_X       <= '0;
      POS_Y       <= '0;
      BUTTONS     <= '0;
      CLICK_PRESS <= '0;
      UPDATE_STB  <= 1'b0;
      BUSY        <= 1'b0;
      OVERRUN     <= 1'b0;
    end else begin
      int_d       <= INTERRUPT;
      UPDATE_STB  <= 1'b0;
      CLICK_PRESS <= '0;

      // Packets that cannot start right away go to the one-deep buffer; a full buffer drops them.
      if (int_edge && (SET_EN || state != IDLE)) begin
        if (!pending) begin
          pend_pkt <= new_pkt;
          pending  <= 1'b1;
        end else if (!SET_EN) begin
          OVERRUN <= 1'b1;
        end
      end

      if (SET_EN) begin
        POS_X      <= set_x_lim;
        POS_Y      <= set_y_lim;
        UPDATE_STB <= 1'b1;
        OVERRUN    <= 1'b0;
        state      <= IDLE;
        BUSY       <= 1'b0;
      end else begin
        case (state)
          IDLE: begin
            if (pending) begin
              pkt   <= pend_pkt;
              state <= SUM;
              BUSY  <= 1'b1;
              if (int_edge) pend_pkt <= new_pkt;
              else          pending  <= 1'b0;
            end else if (int_edge) begin
              pkt   <= new_pkt;
              state <= SUM;
              BUSY  <= 1'b1;
            end else begin
              BUSY <= 1'b0;
            end
          end
          SUM: begin
            acc_x <= sum_x;
            acc_y <= sum_y;
            state <= LIMIT;
          end
          LIMIT: state <= do_commit ? IDLE : WRAP;
          WRAP: begin
            acc_x <= step_x;
            acc_y <= step_y;
            if (do_commit) state <= IDLE;
          end
          default: state <= IDLE;
        endcase

        // BUSY stays high through the cycle in which the committed result appears.
        if (do_commit) begin
          POS_X       <= cx[POS_W-1:0];
          POS_Y       <= cy[POS_W-1:0];
          BUTTONS     <= pkt_buttons;
          CLICK_PRESS <= pkt_buttons & ~BUTTONS;
          UPDATE_STB  <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_mouse_pos_tracker.sv
// Directed and randomized checks of mouse_pos_tracker against an arithmetic position model.
module tb_mouse_pos_tracker;

  localparam int POS_W = 10, X_MAX = 159, Y_MAX = 119, SENS_SHIFT = 0;
  localparam bit Y_INVERT = 1'b1;

  logic CLK = 1'b0, RESET = 1'b0;
  logic [7:0] MOUSE_STATUS = '0, MOUSE_DX = '0, MOUSE_DY = '0;
  logic INTERRUPT = 1'b0, WRAP_MODE = 1'b0, SET_EN = 1'b0;
  logic [POS_W-1:0] SET_X = '0, SET_Y = '0, POS_X, POS_Y;
  logic [2:0] BUTTONS, CLICK_PRESS;
  logic UPDATE_STB, BUSY, OVERRUN;

  int checks = 0, errors = 0;
  int mx = 0, my = 0;
  logic [2:0] mb = '0;

  always #5 CLK = ~CLK;

  mouse_pos_tracker #(.POS_W(POS_W), .X_MAX(X_MAX), .Y_MAX(Y_MAX), .Y_INVERT(Y_INVERT),
                      .SENS_SHIFT(SENS_SHIFT)) dut (
    .CLK(CLK), .RESET(RESET), .MOUSE_STATUS(MOUSE_STATUS), .MOUSE_DX(MOUSE_DX),
    .MOUSE_DY(MOUSE_DY), .INTERRUPT(INTERRUPT), .WRAP_MODE(WRAP_MODE), .SET_EN(SET_EN),
    .SET_X(SET_X), .SET_Y(SET_Y), .POS_X(POS_X), .POS_Y(POS_Y), .BUTTONS(BUTTONS),
    .CLICK_PRESS(CLICK_PRESS), .UPDATE_STB(UPDATE_STB), .BUSY(BUSY), .OVERRUN(OVERRUN)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic int dec(input logic s, input logic v, input logic [7:0] m);
    if (v) return s ? -256 : 255;
    return s ? int'(m) - 256 : int'(m);
  endfunction

  function automatic int wrapv(input int p, input int lim);
    return ((p % (lim + 1)) + (lim + 1)) % (lim + 1);
  endfunction

  function automatic int clampv(input int p, input int lim);
    return (p < 0) ? 0 : (p > lim) ? lim : p;
  endfunction

  // Number of +/-(lim+1) corrections needed to bring p into range.
  function automatic int iters(input int p, input int lim);
    if (p < 0)   return (-p + lim) / (lim + 1);
    if (p > lim) return p / (lim + 1);
    return 0;
  endfunction

  task automatic pulse(input logic [7:0] st, input logic [7:0] dx, input logic [7:0] dy);
    @(negedge CLK);
    MOUSE_STATUS = st; MOUSE_DX = dx; MOUSE_DY = dy; INTERRUPT = 1'b1;
    @(negedge CLK);
    INTERRUPT = 1'b0;
  endtask

  task automatic wait_upd(output int lat);
    lat = 1;
    while (UPDATE_STB !== 1'b1 && lat < 20) begin
      @(negedge CLK);
      lat++;
    end
  endtask

  task automatic set_pos(input int x, input int y);
    @(negedge CLK);
    SET_EN = 1'b1; SET_X = POS_W'(x); SET_Y = POS_W'(y);
    @(negedge CLK);
    SET_EN = 1'b0;
    mx = (x > X_MAX) ? X_MAX : x;
    my = (y > Y_MAX) ? Y_MAX : y;
    chk("set_upd", UPDATE_STB, 1);
    chk("set_x", POS_X, mx);
    chk("set_y", POS_Y, my);
    chk("set_ovr", OVERRUN, 0);
    chk("set_click", CLICK_PRESS, 0);
  endtask

  task automatic send_and_check(input logic [7:0] st, input logic [7:0] dx, input logic [7:0] dy,
                                input logic wm);
    int dxv, dyv, nx, ny, lat_exp, lat;
    logic [2:0] click_exp;
    dxv = dec(st[4], st[6], dx) >>> SENS_SHIFT;
    dyv = (Y_INVERT ? -dec(st[5], st[7], dy) : dec(st[5], st[7], dy)) >>> SENS_SHIFT;
    nx = mx + dxv;
    ny = my + dyv;
    if (wm) begin
      lat_exp = 3 + ((iters(nx, X_MAX) > iters(ny, Y_MAX)) ? iters(nx, X_MAX) : iters(ny, Y_MAX));
      mx = wrapv(nx, X_MAX);
      my = wrapv(ny, Y_MAX);
    end else begin
      lat_exp = 3;
      mx = clampv(nx, X_MAX);
      my = clampv(ny, Y_MAX);
    end
    click_exp = st[2:0] & ~mb;
    mb = st[2:0];
    WRAP_MODE = wm;
    pulse(st, dx, dy);
    wait_upd(lat);
    chk("latency", lat, lat_exp);
    chk("pos_x", POS_X, mx);
    chk("pos_y", POS_Y, my);
    chk("buttons", BUTTONS, mb);
    chk("click", CLICK_PRESS, click_exp);
    @(negedge CLK);
    chk("upd_single", UPDATE_STB, 0);
    chk("click_single", CLICK_PRESS, 0);
  endtask

  initial begin
    int cnt;
    repeat (3) @(negedge CLK);
    RESET = 1'b1;
    @(negedge CLK);
    chk("rst_x", POS_X, 0);
    chk("rst_y", POS_Y, 0);
    chk("rst_btn", BUTTONS, 0);
    chk("rst_click", CLICK_PRESS, 0);
    chk("rst_upd", UPDATE_STB, 0);
    chk("rst_busy", BUSY, 0);
    chk("rst_ovr", OVERRUN, 0);

    // First packet: +10 / -5 (inverted), Y clamps at 0; BUSY covers three cycles.
    chk("busy_pre", BUSY, 0);
    pulse(8'h08, 8'h0A, 8'h05);
    chk("busy_n1", BUSY, 1);
    chk("upd_n1", UPDATE_STB, 0);
    @(negedge CLK);
    chk("busy_n2", BUSY, 1);
    chk("upd_n2", UPDATE_STB, 0);
    @(negedge CLK);
    chk("busy_n3", BUSY, 1);
    chk("upd_n3", UPDATE_STB, 1);
    chk("first_x", POS_X, 10);
    chk("first_y", POS_Y, 0);
    @(negedge CLK);
    chk("busy_n4", BUSY, 0);
    chk("upd_n4", UPDATE_STB, 0);
    mx = 10; my = 0;

    // Right edge: saturate, then one-step wrap, then two-step wrap from a -256 overflow.
    set_pos(150, 60);
    send_and_check(8'h08, 8'h14, 8'h00, 1'b0);
    chk("sat_x159", POS_X, 159);
    set_pos(150, 60);
    send_and_check(8'h08, 8'h14, 8'h00, 1'b1);
    chk("wrap_x10", POS_X, 10);
    set_pos(5, 5);
    send_and_check(8'h58, 8'h00, 8'h00, 1'b1);
    chk("wrap_x69", POS_X, 69);

    // Back-to-back packets: second is buffered, third arrives while buffer full and is dropped.
    set_pos(5, 5);
    WRAP_MODE = 1'b1;
    pulse(8'h58, 8'h00, 8'h00);
    @(negedge CLK);
    MOUSE_STATUS = 8'h08; MOUSE_DX = 8'h0A; MOUSE_DY = 8'h00; INTERRUPT = 1'b1;
    @(negedge CLK);
    INTERRUPT = 1'b0;
    @(negedge CLK);
    MOUSE_STATUS = 8'h08; MOUSE_DX = 8'h30; MOUSE_DY = 8'h00; INTERRUPT = 1'b1;
    @(negedge CLK);
    INTERRUPT = 1'b0;
    chk("b2b_upd_a", UPDATE_STB, 1);
    chk("b2b_xa", POS_X, 69);
    chk("b2b_ya", POS_Y, 5);
    chk("overrun_set", OVERRUN, 1);
    cnt = 0;
    repeat (2) begin
      @(negedge CLK);
      if (UPDATE_STB) cnt++;
    end
    chk("b2b_gap", cnt, 0);
    @(negedge CLK);
    chk("b2b_upd_b", UPDATE_STB, 1);
    chk("b2b_xb", POS_X, 79);
    chk("b2b_yb", POS_Y, 5);
    cnt = 0;
    repeat (10) begin
      @(negedge CLK);
      if (UPDATE_STB) cnt++;
    end
    chk("dropped_no_upd", cnt, 0);
    chk("dropped_x", POS_X, 79);
    chk("overrun_sticky", OVERRUN, 1);
    set_pos(79, 5);

    // Button presses.
    send_and_check(8'h09, 8'h00, 8'h00, 1'b0);
    chk("click_l", CLICK_PRESS, 0);
    send_and_check(8'h0B, 8'h00, 8'h00, 1'b0);
    chk("btn_lr", BUTTONS, 3'b011);

    // SET during LIMIT aborts the packet, with out-of-range load values clamped.
    WRAP_MODE = 1'b0;
    pulse(8'h08, 8'h0A, 8'h00);
    @(negedge CLK);
    SET_EN = 1'b1; SET_X = 10'd300; SET_Y = 10'd300;
    @(negedge CLK);
    SET_EN = 1'b0;
    chk("abort_upd", UPDATE_STB, 1);
    chk("abort_x", POS_X, 159);
    chk("abort_y", POS_Y, 119);
    chk("abort_busy", BUSY, 0);
    chk("abort_btn", BUTTONS, 3'b011);
    chk("abort_click", CLICK_PRESS, 0);
    cnt = 0;
    repeat (6) begin
      @(negedge CLK);
      if (UPDATE_STB) cnt++;
    end
    chk("abort_no_commit", cnt, 0);
    chk("abort_x_hold", POS_X, 159);
    mx = 159; my = 119;

    // Reset while in LIMIT.
    pulse(8'h08, 8'h01, 8'h00);
    @(negedge CLK);
    RESET = 1'b0;
    #1;
    chk("mid_rst_x", POS_X, 0);
    chk("mid_rst_y", POS_Y, 0);
    chk("mid_rst_btn", BUTTONS, 0);
    chk("mid_rst_busy", BUSY, 0);
    chk("mid_rst_upd", UPDATE_STB, 0);
    @(negedge CLK);
    RESET = 1'b1;
    repeat (4) @(negedge CLK);
    chk("post_rst_x", POS_X, 0);
    chk("post_rst_busy", BUSY, 0);
    mx = 0; my = 0; mb = '0;

    // Randomized packets and occasional bus loads.
    for (int i = 0; i < 150; i++) begin
      logic [7:0] st;
      if ($urandom_range(0, 9) == 0) set_pos($urandom_range(0, 400), $urandom_range(0, 400));
      st = 8'($urandom) | 8'h08;
      if ($urandom_range(0, 5) != 0) st[7:6] = 2'b00;
      send_and_check(st, 8'($urandom), 8'($urandom), 1'($urandom));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/mouse_pos_tracker.md
Name: mouse_pos_tracker

Overview:
- Parametrised successor to the mouse position calculator.
- Converts PS/2 packets into absolute screen X/Y and button state.
- Packet decode: 9-bit signed deltas, overflow saturation, Y inversion, sensitivity shift, saturate or wrap edge mode, bus-writable position, pending-event buffering.
- Sits between the PS/2 mouse transceiver (STATUS/DX/DY/INTERRUPT) and the processor bus / VGA cursor logic.

Parameters:
- POS_W, 10, width of position outputs.
- X_MAX, 159, largest legal X. Must be < 2^POS_W.
- Y_MAX, 119, largest legal Y. Must be < 2^POS_W.
- Y_INVERT, 1, 1 = negate DY (PS/2 up-positive becomes screen down-positive).
- SENS_SHIFT, 0, arithmetic right shift applied to each delta (0..3).

Ports:
- CLK  in  1  clock.
- RESET  in  1  reset, asynchronous, active-low.
- MOUSE_STATUS  in  8  {YV,XV,YS,XS,1,M,R,L}.
- MOUSE_DX  in  8  X delta magnitude bits.
- MOUSE_DY  in  8  Y delta magnitude bits.
- INTERRUPT  in  1  packet-ready level; rising edge = new packet.
- WRAP_MODE  in  1  0 = saturate at edges, 1 = wrap around.
- SET_EN  in  1  one-cycle strobe: load SET_X/SET_Y.
- SET_X  in  POS_W  position to load.
- SET_Y  in  POS_W  position to load.
- POS_X  out  POS_W  cursor X.
- POS_Y  out  POS_W  cursor Y.
- BUTTONS  out  3  {M,R,L} from last committed packet.
- CLICK_PRESS  out  3  one-cycle pulse per button 0->1 transition.
- UPDATE_STB  out  1  one-cycle pulse when POS_X/POS_Y change source (commit or set).
- BUSY  out  1  FSM not in IDLE.
- OVERRUN  out  1  sticky; set when a packet edge is dropped; cleared by SET_EN.

Behaviour:
- Reset values: all outputs 0, FSM in IDLE, pending flag 0, edge register 0.
- Edge detect: int_d registered from INTERRUPT; edge = INTERRUPT & ~int_d. STATUS/DX/DY are sampled in the edge cycle N into a packet buffer.
- FSM states: IDLE, SUM, LIMIT, WRAP.
- IDLE: on edge (or pending=1), go to SUM.
- SUM: compute each axis as a signed (POS_W+2)-bit sum: pos + scaled delta. Go to LIMIT.
- LIMIT:
  - Saturate mode: clamp <0 to 0 and >MAX to MAX, commit, return to IDLE.
  - Wrap mode: if either axis is out of range, go to WRAP; otherwise commit and go to IDLE.
- WRAP: each cycle, add MAX+1 to any axis <0 or subtract MAX+1 from any axis >MAX. Stay in WRAP until both axes are in range, then commit and go to IDLE. Bounded at 3 iterations for MAX >= 85.
- Delta decode:
  - delta = {XS,DX} as 9-bit two's complement.
  - If XV=1, delta = XS ? -256 : +255. Same rule for Y with YV/YS/DY.
  - If Y_INVERT, negate the Y delta.
  - Then apply an arithmetic shift right by SENS_SHIFT. -1 >>> n stays -1.
- Latency (saturate mode, or wrap mode with no wrap needed): edge in cycle N; POS/BUTTONS/CLICK_PRESS/UPDATE_STB are valid in cycle N+3. Each wrap iteration adds 1 cycle.
- Commit: POS_X/POS_Y/BUTTONS update together; CLICK_PRESS = new & ~old buttons; UPDATE_STB=1 for exactly one cycle.
- Edge while BUSY: if pending=0, buffer the packet and set pending; it is processed immediately after commit (IDLE->SUM without waiting). If pending=1, drop the new packet and set OVERRUN.
- Edge in the same cycle as commit: counts as "while BUSY".
- SET_EN:
  - Highest priority. Loads min(SET_X,X_MAX) and min(SET_Y,Y_MAX).
  - Aborts any in-flight calculation (FSM -> IDLE), clears OVERRUN, pulses UPDATE_STB next cycle. Pending packet is retained.
  - BUTTONS unchanged; CLICK_PRESS stays 0.
- SET_EN together with an edge: set wins for position; the edge packet becomes pending.
- RESET asserted mid-operation: immediate return to reset values; no partial commit.
- WRAP_MODE is sampled in LIMIT only.

Decomposition:
- Package mouse_pkg:
  - state enum (IDLE/SUM/LIMIT/WRAP);
  - status bit indices (L=0, R=1, M=2, XS=4, YS=5, XV=6, YV=7);
  - a delta width constant (9).
- Sub-module mouse_axis_unit, instantiated twice (X, Y):
  - delta decode, shift, sum, clamp/wrap-step combinational logic;
  - parameters POS_W, MAX, INVERT, SENS_SHIFT.
- The FSM, pending buffer and strobes stay in the top.

Test Plan:
- Reset, then DX=8'h0A, XS=0, DY=8'h05, YS=0 (Y_INVERT=1), edge -> cycle N+3 POS=(10,0) (Y clamped from -5), UPDATE_STB single pulse, BUSY high for 3 cycles.
- SET (150,60), then DX=8'h14 (+20), WRAP_MODE=0 -> POS_X=159. Repeat with WRAP_MODE=1 -> POS_X=10 (170-160), one WRAP cycle, strobe at N+4.
- SET (5,5), XV=1 XS=1, WRAP_MODE=1 -> delta -256; sum -251 -> -91 -> 69; two WRAP cycles, POS_X=69.
- Three edges 1 cycle apart -> first committed, second processed back-to-back (commit at +3 after the first), third dropped, OVERRUN=1; SET_EN clears it.
- STATUS L=1 then L=1,R=1 -> CLICK_PRESS=3'b001 then 3'b010; BUTTONS=3'b011.
- SET_EN at cycle N+2 of an in-flight packet, SET (300,300) -> POS=(159,119), FSM IDLE, no commit from the aborted packet; RESET asserted in LIMIT -> all outputs 0.
